axis_fifo_packet_sync: RTL

- Synchronous single-clock AXI4-Stream FIFO. Next generation of the team's basic sync FIFO.
- Adds: tlast pass-through, an optional packet (store-and-forward) mode, a stored-packet count, and registered almost-full/almost-empty flags with parameterised thresholds.
- Sits between stream producers and consumers that need whole-packet release, for example DMA writers and network framers.
- Storage is inferred block RAM with a registered output stage.

---
 rtl/axis_fifo_packet_sync.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/axis_fifo_packet_sync.sv
// axis_fifo_packet_sync
// Single-clock AXI4-Stream FIFO with tlast pass-through. The FIFO can optionally
// hold words back until a whole packet has been stored (store-and-forward).
// It also reports a stored-packet count and registered almost-full/almost-empty flags.
// Words are held in an inferred block RAM. A registered output stage presents
// m_axis_tdata/m_axis_tlast, and that stage counts toward DEPTH.
module axis_fifo_packet_sync #(
  parameter int AXIS_TDATA_WIDTH    = 32,
  parameter int ADDR_WIDTH          = 9,
  parameter int PACKET_MODE         = 0,
  parameter int ALMOST_FULL_THRESH  = (2 ** ADDR_WIDTH) - 16,
  parameter int ALMOST_EMPTY_THRESH = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  output logic [ADDR_WIDTH:0]         count,
  output logic [ADDR_WIDTH:0]         packet_count,
  output logic                        almost_full,
  output logic                        almost_empty,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int WORD_WIDTH = AXIS_TDATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DepthC    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AfThreshC = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AeThreshC = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESH);

  if (ALMOST_FULL_THRESH < 0 || ALMOST_FULL_THRESH > DEPTH) begin : gBadAfThresh
    $error("axis_fifo_packet_sync: ALMOST_FULL_THRESH must lie in 0..DEPTH");
  end
  if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH) begin : gBadAeThresh
    $error("axis_fifo_packet_sync: ALMOST_EMPTY_THRESH must lie in 0..DEPTH");
  end

  // Each RAM word is {tlast, tdata}.
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] outWord_q;

  logic [ADDR_WIDTH:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [ADDR_WIDTH:0] pktCount_q, pktCount_d;
  logic                sReady_q;
  logic                mValid_q, mValid_d;
  logic                aFull_q, aEmpty_q;
  logic                inPkt_q, inPkt_d;

  logic wrEn;
  logic rdEn;
  logic outLast;
  logic ramHasData;
  logic releaseOk;
  logic loadOut;

  // Handshake strobes, occupancy arithmetic and the decision to refill the output stage.
  always_comb begin
    outLast    = outWord_q[WORD_WIDTH-1];
    wrEn       = s_axis_tvalid & sReady_q;
    rdEn       = mValid_q & m_axis_tready;
    count_d    = count_q + (ADDR_WIDTH + 1)'(wrEn) - (ADDR_WIDTH + 1)'(rdEn);
    pktCount_d = pktCount_q + (ADDR_WIDTH + 1)'(wrEn & s_axis_tlast)
                            - (ADDR_WIDTH + 1)'(rdEn & outLast);

    inPkt_d = inPkt_q;
    if (rdEn) begin
      inPkt_d = ~outLast;
    end

    // The wrPtr/rdPtr MSB distinguishes a full RAM from an empty one.
    ramHasData = (wrPtr_q != rdPtr_q);

    // The word written this cycle is not yet readable from RAM. A packet therefore counts
    // toward release only once its tlast is registered, minus any tlast leaving now.
    // A full FIFO also releases its head, so a packet larger than the FIFO cannot deadlock.
    releaseOk = 1'b1;
    if (PACKET_MODE != 0) begin
      releaseOk = (pktCount_q > (ADDR_WIDTH + 1)'(rdEn & outLast)) ||
                  inPkt_d || (count_q == DepthC);
    end

    loadOut  = ramHasData & releaseOk & (~mValid_q | m_axis_tready);
    mValid_d = mValid_q;
    if (loadOut) begin
      mValid_d = 1'b1;
    end else if (rdEn) begin
      mValid_d = 1'b0;
    end

    wrPtr_d = wrPtr_q + (ADDR_WIDTH + 1)'(wrEn);
    rdPtr_d = rdPtr_q + (ADDR_WIDTH + 1)'(loadOut);
  end

  // Control state. Reset discards every stored word and any partial packet.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      pktCount_q <= '0;
      sReady_q   <= 1'b0;
      mValid_q   <= 1'b0;
      aFull_q    <= 1'b0;
      aEmpty_q   <= 1'b1;
      inPkt_q    <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      pktCount_q <= pktCount_d;
      sReady_q   <= (count_d < DepthC);
      mValid_q   <= mValid_d;
      aFull_q    <= (count_d >= AfThreshC);
      aEmpty_q   <= (count_d <= AeThreshC);
      inPkt_q    <= inPkt_d;
    end
  end

  // Block-RAM write port. Contents are never cleared.
  always_ff @(posedge aclk) begin
    if (wrEn) begin
      mem[wrPtr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Synchronous RAM read into the output register. The register holds its word during a stall.
  always_ff @(posedge aclk) begin
    if (loadOut) begin
      outWord_q <= mem[rdPtr_q[ADDR_WIDTH-1:0]];
    end
  end

  assign count         = count_q;
  assign packet_count  = pktCount_q;
  assign almost_full   = aFull_q;
  assign almost_empty  = aEmpty_q;
  assign s_axis_tready = sReady_q;
  assign m_axis_tdata  = outWord_q[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast  = outLast;
  assign m_axis_tvalid = mValid_q;

endmodule
